// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl
// Radix-2 Booth sequencer for a signed WIDTH x WIDTH -> 2*WIDTH product.
// One add / subtract / pass per cycle through an adder that lives outside
// this block, so the processor's existing ripple-carry adder is reused.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; hi/lo hold the last product
// S_RUN  | one Booth iteration per edge, WIDTH edges in total
// S_DONE | product final on hi/lo; done high for this one cycle
module booth_mul_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             q_1;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic             ext;
    logic             accept;

    assign add_a = a_reg;
    assign hi    = a_reg;
    assign lo    = q_reg;
    assign busy  = busy_r;
    assign done  = done_r;

    // start is only honoured outside RUN; operands are never re-captured mid-run
    assign accept = start && (state == S_IDLE || state == S_DONE);

    // Booth recoding of {Q[0], q_1} selects add M, subtract M or pass
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            unique case ({q_reg[0], q_1})
                2'b01: begin
                    add_b   = m_reg;
                    add_cin = 1'b0;
                end
                2'b10: begin
                    add_b   = ~m_reg;
                    add_cin = 1'b1;
                end
                default: begin
                    add_b   = '0;
                    add_cin = 1'b0;
                end
            endcase
        end
    end

    // Sign of the WIDTH+1 bit true sum; add_sum's MSB alone overflows for M = -2^(WIDTH-1)
    assign ext = a_reg[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

    // Sequencer: state, datapath registers and registered busy/done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            q_reg  <= '0;
            m_reg  <= '0;
            q_1    <= 1'b0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        m_reg  <= multiplicand;
                        q_reg  <= multiplier;
                        a_reg  <= '0;
                        q_1    <= 1'b0;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // arithmetic shift right of {ext, sum, Q, q_1}
                    a_reg <= {ext, add_sum[WIDTH-1:1]};
                    q_reg <= {add_sum[0], q_reg[WIDTH-1:1]};
                    q_1   <= q_reg[0];
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: table of hand-computed products, handshake and
// reset sequences, then random operands against a 64-bit signed reference.
module tb_booth_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [32:0] sum_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // external ripple adder stand-in
    assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign add_sum  = sum_full[31:0];
    assign add_cout = sum_full[32];

    booth_mul_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // counts edges after the accepting edge until done, bounded
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;
        logic [63:0] held;
        longint ref_p;
        logic [31:0] rm;
        logic [31:0] rq;
        logic [31:0] corners[5];

        vecs[0] = '{32'd3,        32'd5,        32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[5] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[7] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[8] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

        corners[0] = 32'h00000000;
        corners[1] = 32'h00000001;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h7FFFFFFF;
        corners[4] = 32'h80000000;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_addb", {31'd0, add_cin, add_b}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table of hand-computed products
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].m, vecs[i].q);
            wait_done(lat, bcnt);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd32);
            chk($sformatf("vec%0d_product", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            held = {hi, lo};
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d_hold", i), {hi, lo}, held);
        end

        // handshake: start during RUN ignored, start in DONE accepted
        launch(32'd6, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("hs_latency", 64'(lat + 5), 64'd32);
        chk("hs_ignored_start", {hi, lo}, 64'd42);
        launch(32'd2, 32'd2);
        chk("hs_b2b_busy", 64'(busy), 64'd1);
        chk("hs_b2b_done_low", 64'(done), 64'd0);
        wait_done(lat, bcnt);
        chk("hs_b2b_latency", 64'(lat), 64'd32);
        chk("hs_b2b_product", {hi, lo}, 64'd4);
        repeat (3) begin @(posedge clk); #1; end
        chk("hs_idle_hold", {hi, lo}, 64'd4);
        chk("hs_idle_busy", 64'(busy), 64'd0);

        // reset at iteration 10 abandons the operation
        launch(32'd1234, 32'd5678);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);

        // corner set pairs followed by random operands
        for (int i = 0; i < 1025; i++) begin
            if (i < 25) begin
                rm = corners[i / 5];
                rq = corners[i % 5];
            end else begin
                rm = $urandom;
                rq = $urandom;
            end
            ref_p = longint'(int'(rm)) * longint'(int'(rq));
            launch(rm, rq);
            wait_done(lat, bcnt);
            if (lat != 32 || bcnt != 32) begin
                chk($sformatf("rand%0d_timing", i), {32'(lat), 32'(bcnt)}, {32'd32, 32'd32});
            end
            chk($sformatf("rand%0d_product", i), {hi, lo}, 64'(ref_p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
